uart_frame_sequencer: RTL and testbench

UART_FRAME_SEQUENCER -- requirements
Module: uart_frame_sequencer

---
 rtl/uart_frame_sequencer.sv | 259 +++++++++++++++++++++++++
 tb/tb_uart_frame_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_sequencer.sv
// Packet-oriented UART transmitter: a circular word buffer drained as back-to-back
// frames, followed by an idle gap, with an optional repeat-packet (loop) mode.
//
//   state | meaning
//   IDLE  | line high, waiting for iGo with a non-empty buffer
//   START | start bit (0)
//   DATA  | DATA_BITS data bits, LSB first
//   PAR   | parity bit (only when PARITY != 0)
//   STOP  | STOP_BITS stop bits (1); pop/advance and pick next word or GAP
//   GAP   | GAP_CYCLES idle-high cycles, oPktDone on the last one
module uart_frame_sequencer #(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] GAP_CYCLES = 32'd1000
) (
  input  logic                          iClk,
  input  logic                          iRst_N,
  input  logic [DATA_BITS-1:0]          iData,
  input  logic                          iWr,
  input  logic                          iGo,
  input  logic                          iLoop,
  output logic                          oTxD,
  output logic                          oBusy,
  output logic                          oPktDone,
  output logic                          oFull,
  output logic                          oEmpty,
  output logic [$clog2(FIFO_DEPTH):0]   oCount,
  output logic                          oOverflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [15:0]   LP_DIV_M1    = 16'(CLK_DIV - 1);
  localparam logic [3:0]    LP_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LP_STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [31:0]   LP_GAP_M1    = GAP_CYCLES - 32'd1;
  localparam logic [CW-1:0] LP_DEPTH     = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LP_CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] LP_PTR_ONE   = AW'(1);
  localparam logic          LP_ODD       = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_head;
  logic [AW-1:0]        r_tail;
  logic [AW-1:0]        r_send;
  logic [CW-1:0]        r_count;
  logic                 r_overflow;

  state_t               r_state;
  logic [15:0]          r_baud;
  logic [3:0]           r_bit;
  logic [31:0]          r_gap;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_loop;
  logic                 r_txd;
  logic                 r_busy;
  logic                 r_pktdone;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_bit_end;
  logic                 w_stop_end;
  logic                 w_pop;
  logic                 w_wr_ok;
  logic                 w_accept;
  logic                 w_more;
  logic [AW-1:0]        w_send_nxt;
  logic [AW-1:0]        w_rd_addr;
  logic [DATA_BITS-1:0] w_rd_word;
  logic                 w_rd_par;

  assign w_full     = (r_count == LP_DEPTH);
  assign w_empty    = (r_count == '0);
  assign w_bit_end  = (r_baud == 16'd0);
  assign w_stop_end = (r_state == S_STOP) && w_bit_end && (r_bit == LP_STOP_LAST);
  assign w_pop      = w_stop_end && !r_loop;
  // a pop on the same edge frees a slot, so a write into a full buffer still lands
  assign w_wr_ok    = iWr && (!w_full || w_pop);
  assign w_accept   = (r_state == S_IDLE) && iGo && !w_empty;
  assign w_send_nxt = r_send + LP_PTR_ONE;
  assign w_more     = r_loop ? (w_send_nxt != r_tail) : (r_count > LP_CNT_ONE);

  // next word comes from the slot after the current one at STOP end, else from head
  assign w_rd_addr  = (r_state == S_STOP) ? w_send_nxt : r_head;
  assign w_rd_word  = r_mem[w_rd_addr];
  assign w_rd_par   = (^w_rd_word) ^ LP_ODD;

  always_ff @(posedge iClk) begin
    if (w_wr_ok) begin
      r_mem[r_tail] <= iData;
    end
  end

  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) begin
      r_tail     <= '0;
      r_head     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_tail <= r_tail + LP_PTR_ONE;
      end
      if (w_pop) begin
        r_head <= r_head + LP_PTR_ONE;
      end
      case ({w_wr_ok, w_pop})
        2'b10:   r_count <= r_count + LP_CNT_ONE;
        2'b01:   r_count <= r_count - LP_CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (iWr && !w_wr_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit     <= '0;
      r_gap     <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_loop    <= 1'b0;
      r_send    <= '0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
      r_pktdone <= 1'b0;
    end else begin
      r_pktdone <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_txd <= 1'b1;
          if (w_accept) begin
            r_state <= S_START;
            r_send  <= r_head;
            r_loop  <= iLoop;
            r_busy  <= 1'b1;
            r_baud  <= LP_DIV_M1;
            r_shift <= w_rd_word;
            r_par   <= w_rd_par;
          end
        end

        S_START: begin
          r_txd <= 1'b0;
          if (w_bit_end) begin
            r_state <= S_DATA;
            r_baud  <= LP_DIV_M1;
            r_bit   <= '0;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end

        S_DATA: begin
          r_txd <= r_shift[0];
          if (w_bit_end) begin
            r_baud  <= LP_DIV_M1;
            r_shift <= r_shift >> 1;
            if (r_bit == LP_DATA_LAST) begin
              r_bit   <= '0;
              r_state <= (PARITY == 0) ? S_STOP : S_PAR;
            end else begin
              r_bit <= r_bit + 4'd1;
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end

        S_PAR: begin
          r_txd <= r_par;
          if (w_bit_end) begin
            r_state <= S_STOP;
            r_baud  <= LP_DIV_M1;
            r_bit   <= '0;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end

        S_STOP: begin
          r_txd <= 1'b1;
          if (w_bit_end) begin
            r_baud <= LP_DIV_M1;
            if (r_bit == LP_STOP_LAST) begin
              r_bit  <= '0;
              r_send <= w_send_nxt;
              if (w_more) begin
                r_state <= S_START;
                r_shift <= w_rd_word;
                r_par   <= w_rd_par;
              end else begin
                r_state   <= S_GAP;
                r_gap     <= LP_GAP_M1;
                r_pktdone <= (LP_GAP_M1 == 32'd0);
              end
            end else begin
              r_bit <= r_bit + 4'd1;
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end

        S_GAP: begin
          r_txd <= 1'b1;
          if (r_gap == 32'd0) begin
            if (r_loop && iLoop) begin
              r_state <= S_START;
              r_send  <= r_head;
              r_baud  <= LP_DIV_M1;
              r_shift <= w_rd_word;
              r_par   <= w_rd_par;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_gap     <= r_gap - 32'd1;
            r_pktdone <= (r_gap == 32'd1);
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign oTxD      = r_txd;
  assign oBusy     = r_busy;
  assign oPktDone  = r_pktdone;
  assign oFull     = w_full;
  assign oEmpty    = w_empty;
  assign oCount    = r_count;
  assign oOverflow = r_overflow;

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Bench for uart_frame_sequencer: records the serial lines, decodes them as a UART
// receiver would, and compares against words queued by the stimulus.
module tb_uart_frame_sequencer;

  localparam int DIV   = 4;
  localparam int GAP   = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d_data;
  logic       d_wr, d_go, d_loop;
  logic       txd0, busy0, pkt0, full0, empty0, ovf0;
  logic [2:0] cnt0;
  logic [7:0] p_data;
  logic       p_wr, p_go, p_loop;
  logic       txd1, busy1, pkt1, full1, empty1, ovf1;
  logic [2:0] cnt1;
  logic       txd2, busy2, pkt2, full2, empty2, ovf2;
  logic [2:0] cnt2;

  int n_checks = 0;
  int n_errors = 0;

  logic q0[$], q1[$], q2[$], pd_q[$], bz_q[$];
  int   dec_w[$], dec_s[$], dec_p[$], dec_stop[$];
  int   exp_w[$];

  always #5 clk = ~clk;

  uart_frame_sequencer #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                         .FIFO_DEPTH(DEPTH), .GAP_CYCLES(32'(GAP))) u_dut0 (
    .iClk(clk), .iRst_N(rst_n), .iData(d_data), .iWr(d_wr), .iGo(d_go), .iLoop(d_loop),
    .oTxD(txd0), .oBusy(busy0), .oPktDone(pkt0), .oFull(full0), .oEmpty(empty0),
    .oCount(cnt0), .oOverflow(ovf0));

  uart_frame_sequencer #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
                         .FIFO_DEPTH(DEPTH), .GAP_CYCLES(32'(GAP))) u_dut1 (
    .iClk(clk), .iRst_N(rst_n), .iData(p_data), .iWr(p_wr), .iGo(p_go), .iLoop(p_loop),
    .oTxD(txd1), .oBusy(busy1), .oPktDone(pkt1), .oFull(full1), .oEmpty(empty1),
    .oCount(cnt1), .oOverflow(ovf1));

  uart_frame_sequencer #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
                         .FIFO_DEPTH(DEPTH), .GAP_CYCLES(32'(GAP))) u_dut2 (
    .iClk(clk), .iRst_N(rst_n), .iData(p_data), .iWr(p_wr), .iGo(p_go), .iLoop(p_loop),
    .oTxD(txd2), .oBusy(busy2), .oPktDone(pkt2), .oFull(full2), .oEmpty(empty2),
    .oCount(cnt2), .oOverflow(ovf2));

  always @(negedge clk) begin
    q0.push_back(txd0);
    q1.push_back(txd1);
    q2.push_back(txd2);
    pd_q.push_back(pkt0);
    bz_q.push_back(busy0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic clear_rec();
    q0.delete(); q1.delete(); q2.delete(); pd_q.delete(); bz_q.delete();
  endtask

  function automatic logic get_bit(input int which, input int idx);
    case (which)
      0:       return q0[idx];
      1:       return q1[idx];
      default: return q2[idx];
    endcase
  endfunction

  function automatic int qsize(input int which);
    case (which)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic get_busy(input int which);
    case (which)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  // UART receiver: find a 1->0 transition, then sample each bit at its centre
  task automatic decode(input int which, input int has_par);
    int n, i, nb, st;
    logic [7:0] w;
    dec_w.delete(); dec_s.delete(); dec_p.delete(); dec_stop.delete();
    n  = qsize(which);
    nb = 10 + has_par;
    i  = 1;
    while (i < n) begin
      if (get_bit(which, i) == 1'b0 && get_bit(which, i - 1) == 1'b1) begin
        st = i;
        if (st + (nb - 1) * DIV + DIV / 2 >= n) break;
        w = '0;
        for (int k = 0; k < 8; k++) w = {get_bit(which, st + (k + 1) * DIV + DIV / 2), w[7:1]};
        dec_s.push_back(st);
        dec_w.push_back(int'(w));
        dec_p.push_back(has_par != 0 ? int'(get_bit(which, st + 9 * DIV + DIV / 2)) : 0);
        dec_stop.push_back(int'(get_bit(which, st + (nb - 1) * DIV + DIV / 2)));
        i = st + (nb - 1) * DIV + DIV / 2 + 1;
      end else begin
        i++;
      end
    end
  endtask

  // pmode: 0 none, 1 odd, 2 even; gap_idx: frame index after which a packet gap lies
  task automatic check_frames(input string tag, input int pmode, input int gap_idx);
    int flen, m, ones;
    flen = DIV * (pmode != 0 ? 11 : 10);
    chk({tag, "_nframes"}, dec_w.size(), exp_w.size());
    m = (dec_w.size() < exp_w.size()) ? dec_w.size() : exp_w.size();
    for (int k = 0; k < m; k++) begin
      chk({tag, "_word"}, dec_w[k], exp_w[k]);
      chk({tag, "_stop"}, dec_stop[k], 1);
      ones = $countones(exp_w[k]);
      if (pmode == 1) chk({tag, "_par_odd"}, dec_p[k], (ones % 2 == 0) ? 1 : 0);
      if (pmode == 2) chk({tag, "_par_even"}, dec_p[k], (ones % 2 == 1) ? 1 : 0);
      if (k > 0) chk({tag, "_spacing"}, dec_s[k] - dec_s[k - 1],
                     (k - 1 == gap_idx) ? flen + GAP : flen);
    end
  endtask

  task automatic wr0(input logic [7:0] w);
    d_data = w; d_wr = 1'b1;
    @(posedge clk); #1;
    d_wr = 1'b0;
  endtask

  task automatic wrp(input logic [7:0] w);
    p_data = w; p_wr = 1'b1;
    @(posedge clk); #1;
    p_wr = 1'b0;
  endtask

  task automatic go0();
    d_go = 1'b1;
    @(posedge clk); #1;
    d_go = 1'b0;
  endtask

  task automatic wait_idle(input int which, input int budget);
    int t = 0;
    while (get_busy(which) && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= budget) chk("idle_timeout", 1, 0);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_flags(input string tag);
    chk({tag, "_txd"}, txd0, 1);
    chk({tag, "_busy"}, busy0, 0);
    chk({tag, "_pktdone"}, pkt0, 0);
    chk({tag, "_ovf"}, ovf0, 0);
    chk({tag, "_count"}, cnt0, 0);
    chk({tag, "_empty"}, empty0, 1);
    chk({tag, "_full"}, full0, 0);
  endtask

  initial begin
    logic [7:0] w, r;
    int n_pd, p_idx, b_idx, last_end;

    rst_n = 1'b0;
    d_data = '0; d_wr = 1'b0; d_go = 1'b0; d_loop = 1'b0;
    p_data = '0; p_wr = 1'b0; p_go = 1'b0; p_loop = 1'b0;
    #23;
    check_reset_flags("rst");
    chk("rst_txd_par", {txd1, txd2}, 2'b11);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // parity frames: 0x07 plus one random word on the odd and even instances
    r = 8'($urandom);
    clear_rec();
    wrp(8'h07);
    wrp(r);
    chk("par_count", cnt1, 2);
    p_go = 1'b1;
    @(posedge clk); #1;
    p_go = 1'b0;
    wait_idle(1, 400);
    wait_idle(2, 50);
    cycles(4);
    exp_w = '{32'h07, int'(r)};
    decode(1, 1);
    check_frames("odd", 1, -1);
    if (dec_p.size() > 0) chk("odd_07_bit", dec_p[0], 0);
    decode(2, 1);
    check_frames("even", 2, -1);
    if (dec_p.size() > 0) chk("even_07_bit", dec_p[0], 1);

    // fixed four-word packet
    wr0(8'h20); wr0(8'h24); wr0(8'h08); wr0(8'h15);
    chk("A_count", cnt0, 4);
    chk("A_full", full0, 1);
    clear_rec();
    go0();
    chk("A_busy_rise", busy0, 1);
    wait_idle(0, 600);
    cycles(10);
    exp_w = '{32'h20, 32'h24, 32'h08, 32'h15};
    decode(0, 0);
    check_frames("A", 0, -1);
    if (dec_s.size() > 0) chk("A_first_start", dec_s[0], 2);
    chk("A_empty", empty0, 1);
    chk("A_busy", busy0, 0);
    n_pd = 0; p_idx = -1; b_idx = -1;
    for (int k = 0; k < pd_q.size(); k++) if (pd_q[k] === 1'b1) begin n_pd++; p_idx = k; end
    for (int k = 2; k < bz_q.size(); k++) if (bz_q[k] === 1'b0 && b_idx < 0) b_idx = k;
    chk("A_pktdone_pulses", n_pd, 1);
    if (dec_s.size() == 4) begin
      last_end = dec_s[3] + 10 * DIV;
      chk("A_pktdone_in_gap", (p_idx >= last_end && p_idx <= last_end + GAP - 1), 1);
      chk("A_busy_after_gap", (b_idx >= last_end && b_idx <= last_end + GAP), 1);
    end

    // word appended mid-packet, iGo while busy ignored, iGo on empty ignored
    w = 8'($urandom); r = 8'($urandom);
    wr0(w);
    clear_rec();
    go0();
    cycles(10);
    wr0(r);
    cycles(2);
    go0();
    wait_idle(0, 600);
    cycles(60);
    exp_w = '{int'(w), int'(r)};
    decode(0, 0);
    check_frames("C", 0, -1);
    chk("C_busy_end", busy0, 0);
    go0();
    chk("C_go_empty_busy", busy0, 0);
    chk("C_go_empty_empty", empty0, 1);

    // loop mode: two copies, iLoop dropped during the second
    w = 8'($urandom); r = 8'($urandom);
    wr0(w); wr0(r);
    d_loop = 1'b1;
    clear_rec();
    go0();
    begin
      int t = 0;
      while (pkt0 !== 1'b1 && t < 300) begin @(posedge clk); #1; t++; end
      if (t >= 300) chk("loop_pkt_timeout", 1, 0);
    end
    cycles(20);
    chk("D_count_loop", cnt0, 2);
    chk("D_busy_loop", busy0, 1);
    d_loop = 1'b0;
    wait_idle(0, 600);
    cycles(60);
    exp_w = '{int'(w), int'(r), int'(w), int'(r)};
    decode(0, 0);
    check_frames("D", 0, 1);
    n_pd = 0;
    for (int k = 0; k < pd_q.size(); k++) if (pd_q[k] === 1'b1) n_pd++;
    chk("D_pktdone_pulses", n_pd, 2);
    chk("D_count_end", cnt0, 2);

    // reset clears the leftover loop words; then overflow on a depth-4 buffer
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    exp_w.delete();
    for (int k = 0; k < 5; k++) begin
      w = 8'($urandom);
      if (k < DEPTH) exp_w.push_back(int'(w));
      wr0(w);
      if (k == DEPTH - 1) chk("B_ovf_before", ovf0, 0);
    end
    chk("B_full", full0, 1);
    chk("B_count", cnt0, 4);
    chk("B_ovf", ovf0, 1);
    clear_rec();
    go0();
    wait_idle(0, 600);
    cycles(4);
    decode(0, 0);
    check_frames("B", 0, -1);
    chk("B_ovf_sticky", ovf0, 1);
    chk("B_empty", empty0, 1);

    // reset during DATA: line high at once, nothing resumes
    w = 8'($urandom) & 8'hF0;
    wr0(w);
    go0();
    cycles(6);
    chk("E_pre_rst_line", txd0, 0);
    rst_n = 1'b0;
    #1;
    check_reset_flags("E_rst");
    cycles(2);
    rst_n = 1'b1;
    clear_rec();
    go0();
    chk("E_go_busy", busy0, 0);
    cycles(60);
    decode(0, 0);
    chk("E_no_frames", dec_w.size(), 0);
    r = 8'($urandom);
    wr0(r);
    chk("E_count", cnt0, 1);
    clear_rec();
    go0();
    wait_idle(0, 300);
    cycles(4);
    exp_w = '{int'(r)};
    decode(0, 0);
    check_frames("E", 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
